// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_if.sv
// Control/status bundle between the PWM controller (master) and pwm_core (slave).
interface pwm_if import pwm_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH_DEF
);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty;
  logic             pwm_out;
  logic             period_end;
  logic             busy;

  modport master (
    output enable, load, period, duty,
    input  pwm_out, period_end, busy
  );

  modport slave (
    input  enable, load, period, duty,
    output pwm_out, period_end, busy
  );

endinterface

// File: rtl/pwm_shadow.sv
// Active period/duty registers for pwm_core.
// With PWM_SHADOW_EN defined, loads while running are parked in pending
// registers and only become active at the next period wrap, so a period is
// never cut short. Without it, loads hit the active registers immediately.
module pwm_shadow import pwm_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             idle_i,
  input  logic             wrap_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic [WIDTH-1:0] period_act_o,
  output logic [WIDTH-1:0] duty_act_o
);

  logic [WIDTH-1:0] period_act_q;
  logic [WIDTH-1:0] duty_act_q;

`ifdef PWM_SHADOW_EN
  logic [WIDTH-1:0] period_pend_q;
  logic [WIDTH-1:0] duty_pend_q;
  logic             pend_valid_q;

  // Load goes straight to active when idle or exactly at a wrap; otherwise it
  // is held pending (last load wins) and promoted at the next wrap.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here is state, so all updates are non-blocking to
    // avoid ordering races against the readers in pwm_core.
    if (reset) begin
      period_act_q  <= '0;
      duty_act_q    <= '0;
      period_pend_q <= '0;
      duty_pend_q   <= '0;
      pend_valid_q  <= 1'b0;
    end else if (load_i && (idle_i || wrap_i)) begin
      period_act_q <= period_i;
      duty_act_q   <= duty_i;
      pend_valid_q <= 1'b0;
    end else if (load_i) begin
      period_pend_q <= period_i;
      duty_pend_q   <= duty_i;
      pend_valid_q  <= 1'b1;
    end else if (pend_valid_q && (idle_i || wrap_i)) begin
      period_act_q <= period_pend_q;
      duty_act_q   <= duty_pend_q;
      pend_valid_q <= 1'b0;
    end
  end
`else
  // Timing context is irrelevant when loads apply immediately.
  logic shadow_unused;
  assign shadow_unused = idle_i | wrap_i;

  // Load writes the active registers on the same edge (a runt pulse is possible).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act_q <= '0;
      duty_act_q   <= '0;
    end else if (load_i) begin
      period_act_q <= period_i;
      duty_act_q   <= duty_i;
    end
  end
`endif

  assign period_act_o = period_act_q;
  assign duty_act_o   = duty_act_q;

endmodule

// File: rtl/pwm_core.sv
// Registered PWM generator: IDLE/RUN/DRAIN FSM, period counter and duty compare.
// Period is P+1 cycles, high time D cycles (saturating at P+1). pwm_out and
// period_end lag the counter by one cycle. Define PWM_SHADOW_EN for
// double-buffered period/duty updates (see pwm_shadow).
module pwm_core import pwm_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  pwm_if.slave bus
);

  pwm_state_t       state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             pwm_q;
  logic             period_end_q;
  logic             busy_q;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_act;
  logic             run_st;
  logic             wrap;

  assign run_st = (state_q != IDLE);
  // >= lets the counter recover in one cycle if the period shrinks below it.
  assign wrap   = run_st && (cnt_q >= period_act);

  pwm_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .load_i       (bus.load),
    .idle_i       (!run_st),
    .wrap_i       (wrap),
    .period_i     (bus.period),
    .duty_i       (bus.duty),
    .period_act_o (period_act),
    .duty_act_o   (duty_act)
  );

  // FSM, counter and registered outputs in one clocked process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pwm_q        <= run_st && (cnt_q < duty_act);
      period_end_q <= wrap;
      cnt_q        <= (run_st && !wrap) ? cnt_q + WIDTH'(1'b1) : '0;
      // busy rises with the state but falls one cycle after it, so it drops
      // together with the last registered pwm_out/period_end of the run.
      case (state_q)
        IDLE: begin
          busy_q <= bus.enable;
          if (bus.enable) state_q <= RUN;
        end
        RUN, DRAIN: begin
          busy_q <= 1'b1;
          // Dropping enable exactly at a wrap ends the run: that period is done.
          if (bus.enable)  state_q <= RUN;
          else if (wrap)   state_q <= IDLE;
          else             state_q <= DRAIN;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = period_end_q;
  assign bus.busy       = busy_q;

endmodule
